i2s_playback_serializer: RTL and testbench
==========================================

// Module: i2s_playback_serializer
// PURPOSE
//  Downstream consumer of the I2S output block's playback FIFO (show-ahead, 64-bit words).
//  Pops one stereo frame per LRCLK period and shifts it MSB-first onto the DAC data line.
//  Uses standard I2S framing (one-BCLK data delay) and the BCLK/LRCLK produced by the clock controller.
//  Runs entirely in the playback FIFO clock domain.
// PARAMETERS
//  DATA_WIDTH  24  audio bits per channel actually sent (16..32); lower slot bits forced 0
//  CNT_WIDTH   16  width of saturating underflow counter
// PORTS
//  clk              in   1   playback FIFO clock; all logic on rising edge
//  reset            in   1   synchronous, active-high
//  enable           in   1   playback enable (from DMA/control enable)
//  bclk             in   1   bit clock, synchronous to clk, period >= 4 clk
//  lrclk            in   1   word select, changes on bclk falling edge; 0 = left
//  fifo_data        in   64  FIFO head word; [63:32] left, [31:0] right; valid when !fifo_empty
//  fifo_empty       in   1   FIFO empty
//  fifo_read        out  1   one-clk pop strobe (show-ahead acknowledge)
//  dacdat           out  1   serial audio data to codec
//  underflow        out  1   one-clk pulse: frame start found FIFO empty
//  underflow_count  out  CNT_WIDTH  saturating count of underflow events
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, shift/hold registers 0, edge-detect flops 0.
//  Edge detect: bclk_q, lrclk_q register inputs; bclk_fall = bclk_q & ~bclk (one clk late).
//   All serial actions happen in the clk cycle where bclk_fall=1; no other cycle changes dacdat.
//  Boundary: at bclk_fall, lrclk differs from lrclk value captured at previous bclk_fall.
//   Left start = lrclk now 0; right start = lrclk now 1.
//  Shift: on a non-boundary bclk_fall: dacdat <= sh[31]; sh <= {sh[30:0],1'b0}.
//   On a boundary bclk_fall: dacdat <= sh[31] (I2S one-bit tail), then sh <= new channel word.
//   MSB of new word therefore appears on the next bclk_fall after the boundary.
//  Word masking: channel word = {slot[31:32-DATA_WIDTH], zeros}; bits after DATA_WIDTH are 0.
//   Slots longer than 32 BCLKs shift out zeros; slots shorter truncate the word silently.
//  FSM:
//   IDLE: enable=0; dacdat=0, fifo_read=0, sh=0. enable=1 -> WAIT.
//   WAIT: output zeros; on left-start boundary -> fetch (below), go LEFT.
//   LEFT: on right-start boundary load sh <= right_hold -> RIGHT.
//   RIGHT: on left-start boundary fetch -> LEFT.
//   Any state: enable=0 -> IDLE next clk; dacdat=0 next clk; no pop after enable low.
//  Fetch (same clk as left-start boundary):
//   !fifo_empty: fifo_read=1 for exactly that clk; sh <= masked fifo_data[63:32];
//    right_hold <= masked fifo_data[31:0].
//   fifo_empty: no read; sh <= 0, right_hold <= 0; underflow=1 that clk;
//    underflow_count += 1, saturating at all-ones.
//  At most one fifo_read per LRCLK period; never asserted while fifo_empty=1.
//  underflow_count cleared by reset only; holds across enable toggles.
//  enable rising mid-frame: first pop waits for next left-start; partial frame output is 0.
//  Reset mid-frame: takes effect next clk regardless of bclk phase.
// TESTING
//  1 Reset: hold reset 3 clk with bclk toggling -> dacdat=0, fifo_read=0, underflow_count=0.
//  2 Frame: DATA_WIDTH=24, 32 BCLK/slot, fifo_data=64'hA5A5A5FF_3C3C3C00 -> one pop at left start;
//    left MSB 1 on 2nd bclk_fall of slot, 24 bits A5A5A5 then 8 zeros; right 3C3C3C; capture matches.
//  3 Underflow: fifo_empty=1 at 3 successive left starts -> no fifo_read, dacdat all 0,
//    3 underflow pulses, underflow_count=3; fifo refilled -> next frame pops, normal data.
//  4 Saturation: CNT_WIDTH=4, 20 empty frames -> underflow_count stays 4'hF.
//  5 Enable: drop enable mid-left slot -> dacdat 0 next clk, no further pops;
//    raise mid-right slot -> no pop until next left start.
//  6 Short slot: 16 BCLK/slot, DATA_WIDTH=24 -> only top 16 bits per channel sent, one pop/frame.

Source files
------------

// File: rtl/i2s_playback_serializer.sv
// I2S playback serializer: pops one stereo frame per LRCLK period from a show-ahead FIFO
// and shifts it MSB-first onto the DAC data line with standard one-BCLK I2S data delay.
module i2s_playback_serializer #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 bclk,
  input  logic                 lrclk,
  input  logic [63:0]          fifo_data,
  input  logic                 fifo_empty,
  output logic                 fifo_read,
  output logic                 dacdat,
  output logic                 underflow,
  output logic [CNT_WIDTH-1:0] underflow_count
);

  localparam int unsigned SLOT_W = 32;
  // Keeps the top DATA_WIDTH bits of a 32-bit slot word
  localparam logic [SLOT_W-1:0] WORD_MASK = ~({SLOT_W{1'b1}} >> DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_LEFT,
    S_RIGHT
  } state_t;

  state_t            state;
  logic              bclk_q;
  logic              lrclk_q;
  logic [SLOT_W-1:0] sh;
  logic [SLOT_W-1:0] right_hold;

  logic bclk_fall_c;
  logic boundary_c;
  logic left_start_c;
  logic right_start_c;

  // lrclk_q holds the word select captured at the previous bclk falling edge
  always_comb begin
    bclk_fall_c   = bclk_q & ~bclk;
    boundary_c    = bclk_fall_c & (lrclk != lrclk_q);
    left_start_c  = boundary_c & ~lrclk;
    right_start_c = boundary_c & lrclk;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      bclk_q          <= 1'b0;
      lrclk_q         <= 1'b0;
      sh              <= '0;
      right_hold      <= '0;
      fifo_read       <= 1'b0;
      dacdat          <= 1'b0;
      underflow       <= 1'b0;
      underflow_count <= '0;
    end else begin
      bclk_q    <= bclk;
      fifo_read <= 1'b0;
      underflow <= 1'b0;
      if (bclk_fall_c) begin
        lrclk_q <= lrclk;
      end

      if (!enable) begin
        state      <= S_IDLE;
        dacdat     <= 1'b0;
        sh         <= '0;
        right_hold <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            state  <= S_WAIT;
            dacdat <= 1'b0;
            sh     <= '0;
          end

          S_WAIT: begin
            if (left_start_c) begin
              if (!fifo_empty) begin
                fifo_read  <= 1'b1;
                sh         <= fifo_data[63:32] & WORD_MASK;
                right_hold <= fifo_data[31:0] & WORD_MASK;
              end else begin
                sh         <= '0;
                right_hold <= '0;
                underflow  <= 1'b1;
                if (underflow_count != CNT_MAX) begin
                  underflow_count <= underflow_count + CNT_WIDTH'(1);
                end
              end
              state <= S_LEFT;
            end
          end

          S_LEFT: begin
            if (bclk_fall_c) begin
              dacdat <= sh[SLOT_W-1];
              if (right_start_c) begin
                sh    <= right_hold;
                state <= S_RIGHT;
              end else begin
                sh <= {sh[SLOT_W-2:0], 1'b0};
              end
            end
          end

          S_RIGHT: begin
            if (bclk_fall_c) begin
              // Last bit of the right word goes out as the I2S tail of the boundary
              dacdat <= sh[SLOT_W-1];
              if (left_start_c) begin
                if (!fifo_empty) begin
                  fifo_read  <= 1'b1;
                  sh         <= fifo_data[63:32] & WORD_MASK;
                  right_hold <= fifo_data[31:0] & WORD_MASK;
                end else begin
                  sh         <= '0;
                  right_hold <= '0;
                  underflow  <= 1'b1;
                  if (underflow_count != CNT_MAX) begin
                    underflow_count <= underflow_count + CNT_WIDTH'(1);
                  end
                end
                state <= S_LEFT;
              end else begin
                sh <= {sh[SLOT_W-2:0], 1'b0};
              end
            end
          end

          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_playback_serializer.sv
// Directed bench for i2s_playback_serializer: framing, underflow, saturation, enable, short slots.
module tb_i2s_playback_serializer;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        bclk;
  logic        lrclk;
  logic [63:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_read;
  logic        dacdat;
  logic        underflow;
  logic [3:0]  underflow_count;

  int n_checks;
  int n_pass;
  int rd_cnt;
  int uf_cnt;
  int bad_rd;
  int bitcnt;
  int slot;

  i2s_playback_serializer #(
    .DATA_WIDTH(24),
    .CNT_WIDTH (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .bclk           (bclk),
    .lrclk          (lrclk),
    .fifo_data      (fifo_data),
    .fifo_empty     (fifo_empty),
    .fifo_read      (fifo_read),
    .dacdat         (dacdat),
    .underflow      (underflow),
    .underflow_count(underflow_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

  always @(posedge clk) begin
    if (fifo_read) rd_cnt <= rd_cnt + 1;
    if (underflow) uf_cnt <= uf_cnt + 1;
    if (fifo_read && fifo_empty) bad_rd <= bad_rd + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One 4-clk bclk period; falling edge (and lrclk update) first, dacdat sampled after it
  task automatic tick(output logic d);
    @(negedge clk);
    bclk   = 1'b0;
    bitcnt = (bitcnt + 1) % (2 * slot);
    lrclk  = (bitcnt >= slot);
    @(posedge clk);
    #1 d = dacdat;
    @(negedge clk);
    @(negedge clk);
    bclk = 1'b1;
    @(negedge clk);
  endtask

  // Tick until the next tick is a left-start boundary
  task automatic align(output logic any_one);
    logic d;
    any_one = 1'b0;
    for (int i = 0; i < 200 && bitcnt != 2 * slot - 1; i++) begin
      tick(d);
      any_one = any_one | d;
    end
    check("align_reached", 64'(bitcnt), 64'(2 * slot - 1));
  endtask

  // One full frame starting at the left-start tick; tail is the bit out at the boundary
  task automatic run_frame(output logic [63:0] bits, output logic tail);
    logic d;
    bits = '0;
    tick(tail);
    for (int j = 1; j < 2 * slot; j++) begin
      tick(d);
      bits = {bits[62:0], d};
    end
  endtask

  initial begin
    logic [63:0] bits;
    logic        tail;
    logic        d;
    logic        acc;
    int          rd0;
    int          uf0;

    n_checks = 0; n_pass = 0;
    rd_cnt = 0; uf_cnt = 0; bad_rd = 0;
    slot = 32; bitcnt = 0;
    reset = 1'b1; enable = 1'b0; bclk = 1'b1; lrclk = 1'b0;
    fifo_empty = 1'b1; fifo_data = '0;

    // 1: reset with bclk toggling
    tick(d);
    check("reset_dacdat", 64'(dacdat), 64'd0);
    check("reset_fifo_read", 64'(fifo_read), 64'd0);
    check("reset_underflow", 64'(underflow), 64'd0);
    check("reset_count", 64'(underflow_count), 64'd0);
    reset = 1'b0;
    align(acc);
    check("idle_dacdat_zero", 64'(acc), 64'd0);

    // 2: normal frames, 24-bit data in 32-bit slots
    enable = 1'b1; fifo_empty = 1'b0; fifo_data = 64'hA5A5A5FF_3C3C3C00;
    rd0 = rd_cnt;
    run_frame(bits, tail);
    check("frame1_tail", 64'(tail), 64'd0);
    check("frame1_bits", bits, 64'h52D2D280_1E1E1E00);
    check("frame1_pops", 64'(rd_cnt - rd0), 64'd1);
    fifo_data = 64'h12345678_9ABCDEF0;
    rd0 = rd_cnt;
    run_frame(bits, tail);
    check("frame2_tail", 64'(tail), 64'd0);
    check("frame2_bits", bits, 64'h091A2B00_4D5E6F00);
    check("frame2_pops", 64'(rd_cnt - rd0), 64'd1);

    // 3: three underflow frames, then refill
    fifo_empty = 1'b1;
    rd0 = rd_cnt; uf0 = uf_cnt; acc = 1'b0;
    for (int f = 0; f < 3; f++) begin
      run_frame(bits, tail);
      acc = acc | (|bits) | tail;
    end
    check("uf_dacdat_zero", 64'(acc), 64'd0);
    check("uf_no_pops", 64'(rd_cnt - rd0), 64'd0);
    check("uf_pulses", 64'(uf_cnt - uf0), 64'd3);
    check("uf_count3", 64'(underflow_count), 64'd3);
    fifo_empty = 1'b0; fifo_data = 64'hA5A5A5FF_3C3C3C00;
    rd0 = rd_cnt;
    run_frame(bits, tail);
    check("refill_bits", bits, 64'h52D2D280_1E1E1E00);
    check("refill_pops", 64'(rd_cnt - rd0), 64'd1);

    // 4: saturation of the 4-bit counter
    fifo_empty = 1'b1;
    uf0 = uf_cnt;
    for (int f = 0; f < 12; f++) run_frame(bits, tail);
    check("sat_count_at15", 64'(underflow_count), 64'hF);
    for (int f = 0; f < 8; f++) run_frame(bits, tail);
    check("sat_count_held", 64'(underflow_count), 64'hF);
    check("sat_pulses", 64'(uf_cnt - uf0), 64'd20);

    // 5: enable dropped mid-left, raised mid-right
    fifo_empty = 1'b0; fifo_data = 64'hA5A5A5FF_3C3C3C00;
    run_frame(bits, tail);
    rd0 = rd_cnt;
    tick(d);
    for (int j = 1; j <= 8; j++) tick(d);
    check("en_mid_left_bit", 64'(d), 64'd1);
    enable = 1'b0;
    @(posedge clk);
    #1 check("en_drop_dacdat", 64'(dacdat), 64'd0);
    acc = 1'b0;
    for (int i = 0; i < 200 && bitcnt != slot + 5; i++) begin
      tick(d);
      acc = acc | d;
    end
    enable = 1'b1;
    align(d);
    acc = acc | d;
    check("en_off_dacdat_zero", 64'(acc), 64'd0);
    check("en_pops_partial", 64'(rd_cnt - rd0), 64'd1);
    rd0 = rd_cnt;
    run_frame(bits, tail);
    check("en_resume_bits", bits, 64'h52D2D280_1E1E1E00);
    check("en_resume_pops", 64'(rd_cnt - rd0), 64'd1);

    // 6: 16-bclk slots truncate the 24-bit words
    slot = 16; bitcnt = 2 * slot - 1;
    rd0 = rd_cnt;
    run_frame(bits, tail);
    check("short1_bits", bits, 64'h00000000_52D29E1E);
    fifo_data = 64'h8001FF00_0001FFFF;
    run_frame(bits, tail);
    check("short2_tail", 64'(tail), 64'd0);
    check("short2_bits", bits, 64'h00000000_40008000);
    check("short_pops", 64'(rd_cnt - rd0), 64'd2);
    fifo_empty = 1'b1;
    rd0 = rd_cnt;
    run_frame(bits, tail);
    check("short3_tail", 64'(tail), 64'd1);
    check("short3_bits", bits, 64'd0);
    check("short3_no_pop", 64'(rd_cnt - rd0), 64'd0);
    check("short3_count", 64'(underflow_count), 64'hF);

    check("never_read_empty", 64'(bad_rd), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
